matrix_tile_loader_4x4x16: RTL and testbench
============================================

Name: matrix_tile_loader_4x4x16

Overview:
Producer-side front end for the 4x4x4x16 matrix-multiply unit. It accepts a stream of signed 16-bit elements over a valid/ready handshake and assembles them into a 4x4 weight tile and a 4x4 activation tile. It then holds the matrix unit's enable for a fixed number of cycles and signals tile completion. Weight tiles can be reused across successive activation tiles, so the weight load phase is skipped.

Parameters:
MM_LATENCY, 2, cycles mm_enable is held per tile; the matrix unit's results are valid after the last such cycle; legal range 1..15
CNT_W, 4, width of run counter; must hold MM_LATENCY

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input element valid
in_ready  out  1  loader can accept element
in_data  in  16  signed element
keep_weights  in  1  sampled at tile_done; 1 = next tile skips weight phase
abort  in  1  synchronous; discard partially loaded tile
activations  out  16 x [0:3][0:3]  signed activation tile registers, to matrix unit
weights  out  16 x [0:3][0:3]  signed weight tile registers, to matrix unit
mm_enable  out  1  enable to matrix unit
tile_done  out  1  one-cycle pulse; matrix results valid this cycle
load_phase  out  2  0=LOAD_W, 1=LOAD_A, 2=RUN (status/debug)

Behaviour:
- Reset (async assert, takes effect immediately):
  - state=LOAD_W, elem_idx=0, run_cnt=0.
  - All activations/weights registers = 0.
  - mm_enable=0, tile_done=0, in_ready=0 while reset is high.
- Handshake:
  - A transfer occurs on a rising edge with in_valid && in_ready.
  - in_ready = (state==LOAD_W || state==LOAD_A) && !abort. It is combinational from state and abort only, never from in_valid.
  - in_data and in_valid may change freely while in_ready=0; nothing is captured.
- Element ordering: row-major. Element index i (0..15) writes tile[i>>2][i&3].
- LOAD_W:
  - Each transfer writes weights[elem_idx] and increments elem_idx.
  - The transfer at elem_idx==15 sets elem_idx=0 and moves to LOAD_A.
- LOAD_A:
  - Each transfer writes activations[elem_idx] and increments elem_idx.
  - The transfer at elem_idx==15 sets elem_idx=0, run_cnt=0 and moves to RUN.
- RUN:
  - mm_enable=1 (registered output) for exactly MM_LATENCY consecutive cycles, starting the cycle after the last activation transfer.
  - in_ready=0 throughout.
  - Tile registers are stable for the whole RUN and for the tile_done cycle.
  - On the cycle run_cnt reaches MM_LATENCY-1: next cycle mm_enable=0, tile_done=1 for one cycle.
  - keep_weights is sampled on that same cycle. 1 goes to LOAD_A; 0 goes to LOAD_W.
- The tile_done cycle already belongs to the next load state, so in_ready may be 1 in the same cycle as tile_done (zero-bubble back-to-back).
- Weight registers are only overwritten in LOAD_W. A reused weight tile is bit-identical across tiles.
- abort:
  - In LOAD_W or LOAD_A: elem_idx=0, state=LOAD_W. Tile registers are not cleared, so partial data remains but will be fully overwritten.
  - abort wins over a simultaneous in_valid; that element is dropped because in_ready=0.
  - In RUN: ignored; the tile completes normally.
- Async reset asserted mid-RUN: mm_enable drops immediately and no tile_done is produced.
- Arithmetic: none on data; elements pass through bit-exact, including sign (0x8000 stays -32768).
- Throughput: worst case 32 + MM_LATENCY cycles per tile; with weight reuse, 16 + MM_LATENCY.

Test Plan:
1. Reset, then stream weights 1..16 and activations 17..32, with in_valid held high continuously → weights[0][0]=1, weights[3][3]=16, activations[1][2]=23; mm_enable high for exactly 2 cycles starting the cycle after element 32; tile_done pulses one cycle later; in_ready is 0 during RUN.
2. Random in_valid gaps (about 50% duty) with the same data → register contents identical to scenario 1; transfers counted only on in_valid&&in_ready.
3. keep_weights=1 at tile_done, then stream 16 activations of -1 (0xFFFF) → no weight phase; weights still 1..16; all activations = -1; second tile_done after 16+2 cycles of streaming.
4. abort asserted with in_valid=1 after 7 activations → that element is not accepted; load_phase=0; the next 32 elements fully reload both tiles; no spurious mm_enable.
5. Async reset asserted in the second RUN cycle → mm_enable=0 and all tiles 0 immediately; no tile_done; state LOAD_W after release.
6. MM_LATENCY=1 build with 0x8000 and 0x7FFF corner elements → single-cycle mm_enable; values preserved bit-exact.

Source files
------------

// File: rtl/matrix_tile_loader_4x4x16_if.sv
// Element stream handshake between producer and tile loader.
interface matrix_tile_loader_4x4x16_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/matrix_tile_loader_4x4x16.sv
// Tile loader for the 4x4x4x16 matrix unit: assembles a weight tile and an
// activation tile from a row-major element stream, then holds mm_enable for
// MM_LATENCY cycles and pulses tile_done. Weight tiles may be reused.
module matrix_tile_loader_4x4x16 #(
    parameter int unsigned MM_LATENCY = 2,
    parameter int unsigned CNT_W      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    matrix_tile_loader_4x4x16_if.slave   bus,
    input  logic                         keep_weights,
    input  logic                         abort,
    output logic signed [15:0]           activations [0:3][0:3],
    output logic signed [15:0]           weights     [0:3][0:3],
    output logic                         mm_enable,
    output logic                         tile_done,
    output logic [1:0]                   load_phase
);

    localparam int unsigned IDX_W = 4;

    localparam logic [1:0] LOAD_W = 2'd0;
    localparam logic [1:0] LOAD_A = 2'd1;
    localparam logic [1:0] RUN    = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(15);
    localparam logic [CNT_W-1:0] LAST_RUN = CNT_W'(MM_LATENCY - 1);

    logic [1:0]       state, state_n;
    logic [IDX_W-1:0] elem_idx, elem_idx_n;
    logic [CNT_W-1:0] run_cnt, run_cnt_n;
    logic             mm_enable_n;
    logic             tile_done_n;
    logic             xfer_c;
    logic             wr_w_c;
    logic             wr_a_c;

    // Ready depends only on state, abort and reset so it never loops back through in_valid.
    assign bus.in_ready = ((state == LOAD_W) || (state == LOAD_A)) && !abort && !reset;
    assign xfer_c       = bus.in_valid && bus.in_ready;
    assign load_phase   = state;

    // Next-state, index/counter update and tile write strobes.
    always_comb begin
        state_n     = state;
        elem_idx_n  = elem_idx;
        run_cnt_n   = run_cnt;
        mm_enable_n = 1'b0;
        tile_done_n = 1'b0;
        wr_w_c      = 1'b0;
        wr_a_c      = 1'b0;
        case (state)
            LOAD_W: begin
                if (abort) begin
                    state_n    = LOAD_W;
                    elem_idx_n = '0;
                end else if (xfer_c) begin
                    wr_w_c = 1'b1;
                    if (elem_idx == LAST_IDX) begin
                        elem_idx_n = '0;
                        state_n    = LOAD_A;
                    end else begin
                        elem_idx_n = elem_idx + IDX_W'(1);
                    end
                end
            end
            LOAD_A: begin
                if (abort) begin
                    state_n    = LOAD_W;
                    elem_idx_n = '0;
                end else if (xfer_c) begin
                    wr_a_c = 1'b1;
                    if (elem_idx == LAST_IDX) begin
                        elem_idx_n  = '0;
                        run_cnt_n   = '0;
                        state_n     = RUN;
                        mm_enable_n = 1'b1;
                    end else begin
                        elem_idx_n = elem_idx + IDX_W'(1);
                    end
                end
            end
            RUN: begin
                // abort is deliberately ignored here; a started tile always completes.
                if (run_cnt == LAST_RUN) begin
                    run_cnt_n   = '0;
                    tile_done_n = 1'b1;
                    state_n     = keep_weights ? LOAD_A : LOAD_W;
                end else begin
                    run_cnt_n   = run_cnt + CNT_W'(1);
                    mm_enable_n = 1'b1;
                end
            end
            default: begin
                state_n    = LOAD_W;
                elem_idx_n = '0;
                run_cnt_n  = '0;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= LOAD_W;
            elem_idx  <= '0;
            run_cnt   <= '0;
            mm_enable <= 1'b0;
            tile_done <= 1'b0;
        end else begin
            state     <= state_n;
            elem_idx  <= elem_idx_n;
            run_cnt   <= run_cnt_n;
            mm_enable <= mm_enable_n;
            tile_done <= tile_done_n;
        end
    end

    // Tile storage; writes land row-major at [idx/4][idx%4], data passes bit-exact.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    weights[r][c]     <= '0;
                    activations[r][c] <= '0;
                end
            end
        end else begin
            if (wr_w_c) begin
                weights[elem_idx[3:2]][elem_idx[1:0]] <= bus.in_data;
            end
            if (wr_a_c) begin
                activations[elem_idx[3:2]][elem_idx[1:0]] <= bus.in_data;
            end
        end
    end

endmodule

// File: tb/tb_matrix_tile_loader_4x4x16.sv
// Self-checking bench for matrix_tile_loader_4x4x16: cycle table for the
// back-to-back / weight-reuse flow, scoreboard of expected tiles checked at
// tile_done, and directed sequences for gaps, abort, mid-run reset and a
// single-cycle-latency build.
module tb_matrix_tile_loader_4x4x16;

    localparam int unsigned LAT    = 2;
    localparam int unsigned NROWS  = 53;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic keep1, abort1, keep2, abort2;
    logic signed [15:0] w1 [0:3][0:3];
    logic signed [15:0] a1 [0:3][0:3];
    logic signed [15:0] w2 [0:3][0:3];
    logic signed [15:0] a2 [0:3][0:3];
    logic mm1, done1, mm2, done2;
    logic [1:0] ph1, ph2;

    matrix_tile_loader_4x4x16_if bus1();
    matrix_tile_loader_4x4x16_if bus2();

    matrix_tile_loader_4x4x16 #(.MM_LATENCY(LAT), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .keep_weights(keep1), .abort(abort1),
        .activations(a1), .weights(w1), .mm_enable(mm1), .tile_done(done1), .load_phase(ph1)
    );

    matrix_tile_loader_4x4x16 #(.MM_LATENCY(1), .CNT_W(4)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2), .keep_weights(keep2), .abort(abort2),
        .activations(a2), .weights(w2), .mm_enable(mm2), .tile_done(done2), .load_phase(ph2)
    );

    typedef struct {
        logic        valid;
        logic [15:0] data;
        logic        abort;
        logic        keep;
        logic        exp_ready;
        logic        exp_mm;
        logic        exp_done;
        logic [1:0]  exp_phase;
    } vec_t;

    typedef struct {
        logic [15:0] w [16];
        logic [15:0] a [16];
    } tile_t;

    vec_t  vecs [NROWS];
    tile_t exp_q [$];
    tile_t t;

    int checks;
    int errors;
    int run_len;
    int spurious_mm;

    // Abort if anything hangs far beyond the expected run length.
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cmp_tile1(input string name, input tile_t et);
        int bad;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (w1[i >> 2][i & 3] !== et.w[i]) bad++;
            if (a1[i >> 2][i & 3] !== et.a[i]) bad++;
        end
        chk(name, 32'(bad), 32'd0);
    endtask

    // Scoreboard side: run-length of mm_enable and tile contents at tile_done.
    task automatic monitor();
        tile_t et;
        if (reset) begin
            run_len = 0;
            return;
        end
        if (mm1) begin
            run_len++;
            if (exp_q.size() > 0) cmp_tile1("tile_stable_in_run", exp_q[0]);
        end
        if (done1) begin
            chk("mm_enable_len", 32'(run_len), 32'(LAT));
            run_len = 0;
            chk("tile_done_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                et = exp_q.pop_front();
                cmp_tile1("tile_at_done", et);
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        monitor();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Offer one element to dut1 with the given valid duty (percent) until it is taken.
    task automatic send(input logic [15:0] d, input int duty);
        logic acc;
        int   budget;
        acc    = 1'b0;
        budget = 0;
        while (!acc && budget < 200) begin
            bus1.in_valid = ($urandom_range(99) < 32'(duty));
            bus1.in_data  = bus1.in_valid ? d : 16'($urandom);
            sample();
            if (mm1) spurious_mm++;
            acc = bus1.in_valid && bus1.in_ready;
            advance();
            budget++;
        end
        if (!acc) chk("send_accept", 32'(acc), 32'd1);
        bus1.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            sample();
            got = done1;
            advance();
        end
        chk("tile_done_seen", 32'(got), 32'd1);
    endtask

    initial begin
        int nz;
        int dcnt;
        int nr;
        int bad;
        checks        = 0;
        errors        = 0;
        run_len       = 0;
        spurious_mm   = 0;
        reset         = 1'b0;
        keep1         = 1'b0;
        abort1        = 1'b0;
        keep2         = 1'b0;
        abort2        = 1'b0;
        bus1.in_valid = 1'b0;
        bus1.in_data  = '0;
        bus2.in_valid = 1'b0;
        bus2.in_data  = '0;

        // Cycle table: full load, run, weight-reuse load, run.
        for (int k = 0; k < int'(NROWS); k++) begin
            vecs[k] = '{valid: 1'b0, data: 16'h0, abort: 1'b0, keep: 1'b0,
                        exp_ready: 1'b0, exp_mm: 1'b0, exp_done: 1'b0, exp_phase: 2'd0};
            if (k < 16) begin
                vecs[k].valid = 1'b1; vecs[k].data = 16'(k + 1);
                vecs[k].exp_ready = 1'b1; vecs[k].exp_phase = 2'd0;
            end else if (k < 32) begin
                vecs[k].valid = 1'b1; vecs[k].data = 16'(k + 1);
                vecs[k].exp_ready = 1'b1; vecs[k].exp_phase = 2'd1;
            end else if (k < 34) begin
                vecs[k].valid = 1'b1; vecs[k].data = 16'hDEAD;
                vecs[k].exp_mm = 1'b1; vecs[k].exp_phase = 2'd2;
                vecs[k].keep = (k == 33);
            end else if (k < 50) begin
                vecs[k].valid = 1'b1; vecs[k].data = 16'hFFFF;
                vecs[k].exp_ready = 1'b1; vecs[k].exp_phase = 2'd1;
                vecs[k].exp_done = (k == 34);
            end else if (k < 52) begin
                vecs[k].valid = 1'b1; vecs[k].data = 16'h1234;
                vecs[k].exp_mm = 1'b1; vecs[k].exp_phase = 2'd2;
            end else begin
                vecs[k].exp_ready = 1'b1; vecs[k].exp_done = 1'b1; vecs[k].exp_phase = 2'd0;
            end
        end

        // Reset state.
        #2 reset = 1'b1;
        advance();
        chk("rst_in_ready", 32'(bus1.in_ready), 32'd0);
        chk("rst_mm_enable", 32'(mm1), 32'd0);
        chk("rst_tile_done", 32'(done1), 32'd0);
        chk("rst_phase", 32'(ph1), 32'd0);
        chk("rst_w00", 32'(w1[0][0]), 32'd0);
        chk("rst_a33", 32'(a1[3][3]), 32'd0);
        advance();
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            t.w[i] = 16'(i + 1);
            t.a[i] = 16'(i + 17);
        end
        exp_q.push_back(t);
        for (int i = 0; i < 16; i++) t.a[i] = 16'hFFFF;
        exp_q.push_back(t);

        for (int k = 0; k < int'(NROWS); k++) begin
            bus1.in_valid = vecs[k].valid;
            bus1.in_data  = vecs[k].data;
            abort1        = vecs[k].abort;
            keep1         = vecs[k].keep;
            sample();
            chk($sformatf("row%0d_ready", k), 32'(bus1.in_ready), 32'(vecs[k].exp_ready));
            chk($sformatf("row%0d_mm", k), 32'(mm1), 32'(vecs[k].exp_mm));
            chk($sformatf("row%0d_done", k), 32'(done1), 32'(vecs[k].exp_done));
            chk($sformatf("row%0d_phase", k), 32'(ph1), 32'(vecs[k].exp_phase));
            if (k == 34) begin
                chk("w00_first", 32'(w1[0][0]), 32'd1);
                chk("w33_first", 32'(w1[3][3]), 32'd16);
                chk("a12_first", 32'(a1[1][2]), 32'd23);
            end
            if (k == 52) chk("w33_reused", 32'(w1[3][3]), 32'd16);
            advance();
        end
        bus1.in_valid = 1'b0;
        keep1         = 1'b0;

        // Same data with random valid gaps.
        for (int i = 0; i < 16; i++) begin
            t.w[i] = 16'(i + 1);
            t.a[i] = 16'(i + 17);
        end
        exp_q.push_back(t);
        spurious_mm = 0;
        for (int i = 0; i < 32; i++) begin
            send(16'(i + 1), 50);
            if (i == 15) chk("gap_phase_after_w", 32'(ph1), 32'd1);
        end
        chk("gap_phase_run", 32'(ph1), 32'd2);
        chk("gap_ready_run", 32'(bus1.in_ready), 32'd0);
        chk("gap_no_early_mm", 32'(spurious_mm), 32'd0);
        wait_done();

        // Abort after seven activations, then full reload.
        for (int i = 0; i < 16; i++) send(16'(100 + i), 100);
        for (int i = 0; i < 7; i++) send(16'(200 + i), 100);
        bus1.in_valid = 1'b1;
        bus1.in_data  = 16'hBEEF;
        abort1        = 1'b1;
        sample();
        chk("abort_ready", 32'(bus1.in_ready), 32'd0);
        advance();
        abort1        = 1'b0;
        bus1.in_valid = 1'b0;
        chk("abort_phase", 32'(ph1), 32'd0);
        for (int i = 0; i < 16; i++) begin
            t.w[i] = 16'(300 + i);
            t.a[i] = 16'(400 + i);
        end
        exp_q.push_back(t);
        spurious_mm = 0;
        for (int i = 0; i < 16; i++) send(16'(300 + i), 70);
        for (int i = 0; i < 16; i++) send(16'(400 + i), 70);
        chk("abort_no_spurious_mm", 32'(spurious_mm), 32'd0);
        wait_done();

        // Async reset in the second RUN cycle.
        for (int i = 0; i < 32; i++) send(16'(500 + i), 100);
        sample();
        chk("rr_mm_first", 32'(mm1), 32'd1);
        advance();
        reset = 1'b1;
        #1;
        nz = 0;
        for (int i = 0; i < 16; i++) begin
            if (w1[i >> 2][i & 3] !== 16'h0) nz++;
            if (a1[i >> 2][i & 3] !== 16'h0) nz++;
        end
        chk("rr_mm_drop", 32'(mm1), 32'd0);
        chk("rr_done", 32'(done1), 32'd0);
        chk("rr_ready", 32'(bus1.in_ready), 32'd0);
        chk("rr_tiles_zero", 32'(nz), 32'd0);
        advance();
        advance();
        reset = 1'b0;
        dcnt  = 0;
        for (int i = 0; i < 6; i++) begin
            sample();
            if (done1 || mm1) dcnt++;
            advance();
        end
        chk("rr_no_done", 32'(dcnt), 32'd0);
        chk("rr_phase", 32'(ph1), 32'd0);

        // Single-cycle latency build with extreme values.
        nr = 0;
        bus2.in_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i < 16) bus2.in_data = (i % 2 == 0) ? 16'h8000 : 16'h7FFF;
            else        bus2.in_data = ((i - 16) % 2 == 0) ? 16'h7FFF : 16'h8000;
            sample();
            if (!bus2.in_ready) nr++;
            advance();
        end
        bus2.in_valid = 1'b0;
        chk("l1_ready_load", 32'(nr), 32'd0);
        sample();
        chk("l1_mm", 32'(mm2), 32'd1);
        chk("l1_done_early", 32'(done2), 32'd0);
        chk("l1_phase_run", 32'(ph2), 32'd2);
        advance();
        sample();
        chk("l1_mm_off", 32'(mm2), 32'd0);
        chk("l1_done", 32'(done2), 32'd1);
        chk("l1_phase", 32'(ph2), 32'd0);
        chk("l1_w00_neg", 32'($signed(w2[0][0])), 32'hFFFF8000);
        chk("l1_w33", 32'(w2[3][3]), 32'h7FFF);
        chk("l1_a00", 32'(a2[0][0]), 32'h7FFF);
        chk("l1_a33_neg", 32'($signed(a2[3][3])), 32'hFFFF8000);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (w2[i >> 2][i & 3] !== ((i % 2 == 0) ? 16'h8000 : 16'h7FFF)) bad++;
            if (a2[i >> 2][i & 3] !== ((i % 2 == 0) ? 16'h7FFF : 16'h8000)) bad++;
        end
        chk("l1_tile", 32'(bad), 32'd0);
        advance();
        sample();
        chk("l1_done_pulse", 32'(done2), 32'd0);
        chk("l1_mm_idle", 32'(mm2), 32'd0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
